cfo_est_ctrl: RTL and testbench

- Sequencer for the CFO-estimation datapath.
- Accepts a handshaked stream of complex samples and generates the load strobe for the 24-bit I/Q holding registers.
- Generates clear/enable strobes for the lag-product accumulator, then triggers and waits on the phase (angle) computation.
- One estimate per `start`: fill the lag delay line, accumulate NUM_ACC products, compute the angle, report done.

---
 rtl/cfo_est_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cfo_est_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cfo_est_ctrl.sv
// cfo_est_ctrl: sequencer for the CFO-estimation datapath.
// Define CFO_TIMEOUT_EN to bound the wait on phase_done (err on expiry).
module cfo_est_ctrl #(
  parameter int LAG     = 16,
  parameter int NUM_ACC = 64,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             phase_go,
  input  logic             phase_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_ANGLE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Limits compare against value-1 so a full 2^CNT_W count fits.
  localparam logic [CNT_W-1:0] LAG_LAST = CNT_W'(LAG - 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(NUM_ACC - 1);

  if (LAG < 1 || LAG > 2 ** CNT_W) begin : g_bad_lag
    $error("cfo_est_ctrl: LAG out of range");
  end
  if (NUM_ACC < 1 || NUM_ACC > 2 ** CNT_W) begin : g_bad_acc
    $error("cfo_est_ctrl: NUM_ACC out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 2 ** CNT_W - 1) begin : g_bad_tmo
    $error("cfo_est_ctrl: TIMEOUT out of range");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  logic st_idle;
  logic st_fill;
  logic st_accum;
  logic st_angle;
  logic st_done;
  logic rdy;
  logic accept;
  logic tmo_hit;

  assign st_idle  = (state_q == S_IDLE);
  assign st_fill  = (state_q == S_FILL);
  assign st_accum = (state_q == S_ACCUM);
  assign st_angle = (state_q == S_ANGLE);
  assign st_done  = (state_q == S_DONE);

  assign rdy    = st_fill | st_accum;
  assign accept = rdy & in_valid;

`ifdef CFO_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = st_angle & (tmo_q == TMO_LAST);

  // Count ANGLE cycles; err set on expiry unless phase_done wins.
  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (st_angle) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (st_idle & start) begin
      err_d = 1'b0;
    end else if (tmo_hit & ~phase_done) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = ~rst & err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Sequencing: fill the lag line, accumulate, then wait on the angle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (cnt_q == LAG_LAST) begin
            state_d = S_ACCUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (cnt_q == ACC_LAST) begin
            state_d = S_ANGLE;
            cnt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ANGLE: begin
        if (phase_done | tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sample counter and first-ANGLE-cycle flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign in_ready   = ~rst & rdy;
  assign ld_en      = ~rst & accept;
  assign acc_en     = ~rst & accept & st_accum;
  assign acc_clr    = ~rst & st_idle & start;
  assign phase_go   = ~rst & st_angle & first_q;
  assign busy       = ~rst & ~st_idle;
  assign done       = ~rst & st_done;
  assign sample_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_cfo_est_ctrl.sv
// tb_cfo_est_ctrl: directed + random checks of cfo_est_ctrl
// against a sample-counting reference model.
module tb_cfo_est_ctrl;

  localparam int LAG     = 4;
  localparam int NUM_ACC = 8;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 10;
  localparam int TOT     = LAG + NUM_ACC;
`ifdef CFO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ld_en;
  logic             acc_clr;
  logic             acc_en;
  logic             phase_go;
  logic             phase_done = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] sample_cnt;

  cfo_est_ctrl #(
    .LAG(LAG), .NUM_ACC(NUM_ACC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .ld_en(ld_en), .acc_clr(acc_clr), .acc_en(acc_en),
    .phase_go(phase_go), .phase_done(phase_done),
    .busy(busy), .done(done), .err(err),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: estimate in flight, samples taken, angle cycles.
  bit m_active = 0;
  bit m_fin    = 0;
  bit m_err    = 0;
  int m_n      = 0;
  int m_ang    = 0;

  int c_ld, c_acc, c_clr, c_go, c_done;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic pd, input logic st);
    bit e_rdy, e_ld, e_acc, e_clr, e_go, e_busy, e_done;
    int e_cnt;
    @(negedge clk);
    in_valid = v; phase_done = pd; start = st;
    #1;
    e_rdy  = m_active && !m_fin && m_n < TOT;
    e_ld   = e_rdy && v;
    e_acc  = e_ld && m_n >= LAG;
    e_clr  = !m_active && st;
    e_go   = m_active && !m_fin && m_n == TOT && m_ang == 0;
    e_busy = m_active;
    e_done = m_fin;
    if (!m_active || m_n >= TOT) e_cnt = 0;
    else if (m_n < LAG) e_cnt = m_n;
    else e_cnt = m_n - LAG;
    chk("in_ready", in_ready, e_rdy);
    chk("ld_en", ld_en, e_ld);
    chk("acc_en", acc_en, e_acc);
    chk("acc_clr", acc_clr, e_clr);
    chk("phase_go", phase_go, e_go);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, m_err);
    chk("sample_cnt", sample_cnt, e_cnt);
    c_ld   += int'(ld_en);
    c_acc  += int'(acc_en);
    c_clr  += int'(acc_clr);
    c_go   += int'(phase_go);
    c_done += int'(done);
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_n = 0; m_ang = 0; m_fin = 0; m_err = 0;
      end
    end else if (m_fin) begin
      m_active = 0; m_fin = 0; m_n = 0;
    end else if (m_n < TOT) begin
      if (v) m_n++;
    end else begin
      if (pd) m_fin = 1;
      else if (TMO_EN && m_ang == TIMEOUT - 1) begin
        m_fin = 1; m_err = 1;
      end
      m_ang++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 1; in_valid = 1; phase_done = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_phase_go", phase_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", sample_cnt, 0);
    @(negedge clk);
    #1;
    chk("rst_busy2", busy, 0);
    chk("rst_done2", done, 0);
    rst = 0; start = 0; in_valid = 0; phase_done = 0;
    m_active = 0; m_fin = 0; m_err = 0; m_n = 0; m_ang = 0;
  endtask

  // vmode: 0 valid held, 1 toggling, 2 random. abort_at<0: no abort.
  task automatic run_est(input int vmode, input int lat,
                         input bit st_noise, input int abort_at);
    int  cyc;
    bit  fin_seen;
    bit  ang;
    logic v, pd, st;
    c_ld = 0; c_acc = 0; c_clr = 0; c_go = 0; c_done = 0;
    step(1'b1, 1'b0, 1'b1);
    cyc = 0;
    fin_seen = 0;
    while (!fin_seen && cyc < 400) begin
      if (abort_at >= 0 && m_n == abort_at) begin
        do_reset();
        chk("abort_no_done", c_done, 0);
        chk("abort_ld", c_ld, abort_at);
        return;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ang = m_active && !m_fin && m_n == TOT;
      pd  = ang ? (m_ang >= lat) : 1'($urandom_range(0, 1));
      st  = st_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      fin_seen = m_fin;
      step(v, pd, st);
      cyc++;
    end
    chk("tot_done", c_done, 1);
    chk("tot_ld", c_ld, TOT);
    chk("tot_acc", c_acc, NUM_ACC);
    chk("tot_clr", c_clr, 1);
    chk("tot_go", c_go, 1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat_never;
    lat_never = TMO_EN ? 100000 : 40;
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    run_est(0, 3, 0, -1);
    run_est(1, 3, 0, -1);
    run_est(0, 3, 1, -1);
    run_est(0, 0, 0, -1);
    run_est(0, 3, 0, 6);
    step(1'b0, 1'b0, 1'b0);
    run_est(0, 2, 0, -1);
    run_est(0, lat_never, 0, -1);
    step(1'b0, 1'b0, 1'b0);
    run_est(0, TIMEOUT - 1, 0, -1);
    run_est(0, TIMEOUT, 0, -1);
    for (int i = 0; i < 8; i++) begin
      run_est(2, $urandom_range(0, 12), 1'($urandom_range(0, 1)), -1);
    end
    run_est(2, 1, 1, 7);
    run_est(1, 0, 1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
